multi_toggle_det: RTL
=====================

# multi_toggle_det

Parametrised, multi-channel successor to the single-bit toggle detector. Each of WIDTH asynchronous trigger inputs is synchronised, edge-detected per a runtime-selectable mode (rise/fall/both), and turned into a one-cycle pulse. Each channel also sets a sticky flag, and an optional saturating event counter runs across all channels. The block sits between raw external/status lines and the control FSMs that consume single-cycle events.

## Interface
- WIDTH, 8, number of independent trigger channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (min 2)
- CNT_W, 8, event counter width (min 4)

- clk  input  1  rising-edge system clock
- rst  input  1  asynchronous, active-high reset; one clock, no other clock domains
- trigger  input  WIDTH  raw asynchronous level inputs
- mode  input  2  global edge select: 00 off, 01 rising, 10 falling, 11 both (toggle)
- clear  input  WIDTH  per-channel sticky clear, synchronous, level
- count_clr  input  1  synchronous clear of event_count
- toggle_pulse  output  WIDTH  registered one-cycle edge pulse per channel
- any_pulse  output  1  registered OR of all channel pulses, aligned with toggle_pulse
- sticky  output  WIDTH  per-channel latched "edge seen" flag
- event_count  output  CNT_W  saturating count of channel pulses

## Operation
- Per channel: SYNC_STAGES-deep shift chain s; prev register holds the last synchronised value sN = s[SYNC_STAGES-1].
- Edge terms: rise = sN & ~prev; fall = ~sN & prev; selected by mode (00 → no pulse, 11 → rise|fall).
- toggle_pulse[i] registered from the selected edge term; high exactly one cycle per detected edge.
- any_pulse = OR over next-state pulses, registered in the same flop stage (never lags toggle_pulse).
- sticky[i]: set on toggle_pulse[i] high; cleared by clear[i]; set wins if both occur in the same cycle.
- event_count: each cycle adds popcount(toggle_pulse); saturates at 2^CNT_W−1 (no wrap); count_clr forces 0 and discards that cycle's increment.
- mode changes take effect on the next clock; changing mode never by itself creates a pulse.
- Reset (async assert, sync deassert expected at top level): s, prev, toggle_pulse, any_pulse, sticky, event_count all 0.
- A channel whose trigger is high at reset release produces a rising edge (prev=0) if mode is 01 or 11; this is intended.
- Reset asserted mid-pulse or mid-sync clears everything immediately; no pulse is emitted for history before reset.

## Timing
- Trigger sampled at edge E0 → sN valid after edge E0+SYNC_STAGES−1 → toggle_pulse high in the cycle after edge E0+SYNC_STAGES; latency = SYNC_STAGES+1 edges (3 with defaults).
- Pulses from successive edges on one channel: minimum spacing one cycle; a trigger toggling every cycle yields a pulse every cycle in mode 11.
- sticky rises one cycle after toggle_pulse; event_count updates one cycle after toggle_pulse.
- Trigger pulses shorter than one clk period may be missed; no requirement to catch them.

## Configuration
- MULTI_TOGGLE_DET_COUNT_EN defined: event_count logic and count_clr behaviour as above.
- Undefined: counter removed, event_count tied to 0, count_clr ignored; all other behaviour identical.

## Test plan
- Reset with trigger=0, mode=11: after rst drops, trigger[0] 0→1 at t=12 ns → toggle_pulse[0] high one cycle, 3 edges later; sticky[0]=1 next cycle; event_count=1.
- mode=01, trigger[1] 0→1→0 (20 ns each) → exactly one pulse (rise only); mode=10 repeat → one pulse on fall only.
- Trigger held 1 for 40 ns (no toggle) in mode=11 → no extra pulse; toggle_pulse stays 0.
- All 8 channels toggle in the same cycle → toggle_pulse=8'hFF for one cycle, any_pulse=1, event_count +=8; with CNT_W=4 repeat until count sticks at 15.
- clear[2] and a pulse on channel 2 in the same cycle → sticky[2] remains 1; count_clr with simultaneous pulse → event_count=0.
- rst asserted while trigger[3] edge is in the sync chain → all outputs 0 immediately; no pulse after release if trigger[3]=0.

Source files
------------

// File: rtl/multi_toggle_det.sv
// Multi-channel synchronising edge detector with per-channel pulse and sticky flag.
// Define MULTI_TOGGLE_DET_COUNT_EN to build the saturating event counter.
module multi_toggle_det #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] trigger,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clear,
  input  logic             count_clr,
  output logic [WIDTH-1:0] toggle_pulse,
  output logic             any_pulse,
  output logic [WIDTH-1:0] sticky,
  output logic [CNT_W-1:0] event_count
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  sync_n;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  pulse_d;
  logic [WIDTH-1:0]                  pulse_q;
  logic                              any_q;
  logic [WIDTH-1:0]                  sticky_d;
  logic [WIDTH-1:0]                  sticky_q;

  assign sync_n = sync_q[SYNC_STAGES-1];
  assign rise   = sync_n & ~prev_q;
  assign fall   = ~sync_n & prev_q;

  always_comb begin
    pulse_d = '0;
    unique case (mode)
      2'b01:   pulse_d = rise;
      2'b10:   pulse_d = fall;
      2'b11:   pulse_d = rise | fall;
      default: pulse_d = '0;
    endcase
  end

  // Set has priority over clear so a pulse is never lost to a concurrent clear.
  assign sticky_d = (sticky_q & ~clear) | pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      any_q    <= 1'b0;
      sticky_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], trigger};
      prev_q   <= sync_n;
      pulse_q  <= pulse_d;
      any_q    <= |pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign toggle_pulse = pulse_q;
  assign any_pulse    = any_q;
  assign sticky       = sticky_q;

`ifdef MULTI_TOGGLE_DET_COUNT_EN
  // Extra headroom bits hold count + popcount of up to 32 channels without overflow.
  localparam int unsigned SumW = CNT_W + 6;
  localparam logic [SumW-1:0] CntMax = SumW'({CNT_W{1'b1}});

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [SumW-1:0]  pop;
  logic [SumW-1:0]  sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + SumW'(pulse_q[i]);
    end
    sum = SumW'(count_q) + pop;
    if (count_clr) begin
      count_d = '0;
    end else if (sum > CntMax) begin
      count_d = {CNT_W{1'b1}};
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign event_count = count_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign event_count      = '0;
`endif

endmodule
